// File: rtl/round_sequencer_if.sv
// Button/timer-side signal bundle for round_sequencer.
// slave: the sequencer's view; master: the side driving buttons and timer_done.
interface round_sequencer_if;
  logic       start;
  logic       pause;
  logic       stop;
  logic       timer_done;
  logic       timer_run;
  logic       timer_tick;
  logic [2:0] round_num;
  logic [2:0] state;
  logic       round_end;
  logic       game_over;

  modport slave (
    input  start, pause, stop, timer_done,
    output timer_run, timer_tick, round_num, state, round_end, game_over
  );

  modport master (
    output start, pause, stop, timer_done,
    input  timer_run, timer_tick, round_num, state, round_end, game_over
  );
endinterface

// File: rtl/round_sequencer.sv
// Round/game-flow FSM driving a countdown timer: ready hold, tick prescaler, pause, abort.
// Optional feature macro ROUND_SEQ_PAUSE_EN compiles in the PAUSED state and pause handling.
module round_sequencer #(
  parameter int TICK_DIV     = 100_000_000,
  parameter int READY_CYCLES = 200_000_000,
  parameter int NUM_ROUNDS   = 3
) (
  input  logic              clk,
  input  logic              reset,
  round_sequencer_if.slave  bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int RW = $clog2(READY_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [RW-1:0] READY_LAST = RW'(READY_CYCLES - 1);
  localparam logic [2:0]    ROUND_LAST = 3'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READY     = 3'd1,
    RUN       = 3'd2,
    PAUSED    = 3'd3,
    ROUND_END = 3'd4,
    GAME_OVER = 3'd5
  } state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [RW-1:0] ready_reg, ready_next;
  logic [2:0]    round_reg, round_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      presc_reg <= '0;
      ready_reg <= '0;
      round_reg <= '0;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
      ready_reg <= ready_next;
      round_reg <= round_next;
    end
  end

`ifndef ROUND_SEQ_PAUSE_EN
  logic unused_pause;
  assign unused_pause = bus.pause;
`endif

  always_comb begin
    state_next = state_reg;
    presc_next = presc_reg;
    ready_next = ready_reg;
    round_next = round_reg;
    if (bus.stop) begin
      state_next = IDLE;
      presc_next = '0;
      ready_next = '0;
      round_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_next = READY;
            round_next = 3'd1;
            ready_next = '0;
          end
        end
        READY: begin
          if (ready_reg == READY_LAST) begin
            state_next = RUN;
            presc_next = '0;
          end else begin
            ready_next = ready_reg + 1'b1;
          end
        end
        RUN: begin
          // Prescaler advances on every RUN cycle, including the one a pause lands on.
          presc_next = (presc_reg == PRESC_LAST) ? '0 : presc_reg + 1'b1;
          if (bus.timer_done) begin
            state_next = ROUND_END;
          end
`ifdef ROUND_SEQ_PAUSE_EN
          else if (bus.pause) begin
            state_next = PAUSED;
          end
`endif
        end
`ifdef ROUND_SEQ_PAUSE_EN
        PAUSED: begin
          if (bus.pause) begin
            state_next = RUN;
          end
        end
`endif
        ROUND_END: begin
          if (round_reg == ROUND_LAST) begin
            state_next = GAME_OVER;
          end else begin
            state_next = READY;
            round_next = round_reg + 3'd1;
            ready_next = '0;
          end
        end
        GAME_OVER: begin
          if (bus.start) begin
            state_next = READY;
            round_next = 3'd1;
            ready_next = '0;
          end
        end
        default: begin
          state_next = IDLE;
          presc_next = '0;
          ready_next = '0;
          round_next = '0;
        end
      endcase
    end
  end

  // Outputs decode registers only, so no input reaches an output combinationally.
  assign bus.state      = state_reg;
  assign bus.round_num  = round_reg;
  assign bus.timer_run  = (state_reg == RUN) || (state_reg == PAUSED);
  assign bus.timer_tick = (state_reg == RUN) && (presc_reg == PRESC_LAST);
  assign bus.round_end  = (state_reg == ROUND_END);
  assign bus.game_over  = (state_reg == GAME_OVER);

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer (TICK_DIV=4, READY_CYCLES=3, NUM_ROUNDS=2) with a reload-3 timer model.
module tb_round_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  round_sequencer_if bif ();

  round_sequencer #(.TICK_DIV(4), .READY_CYCLES(3), .NUM_ROUNDS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  // Behavioural countdown timer, reload value 3.
  logic [1:0] tcnt;
  logic       model_en;
  logic       done_force;
  always @(posedge clk) begin
    if (!bif.timer_run) tcnt <= 2'd3;
    else if (bif.timer_tick && tcnt != 2'd0) tcnt <= tcnt - 2'd1;
  end
  assign bif.timer_done = model_en ? (tcnt == 2'd0) : done_force;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end else begin
      $display("chk %s = %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    for (int i = 0; i < budget && bif.state != s; i++) step();
    check_val(tag, {29'd0, bif.state}, {29'd0, s});
  endtask

  task automatic wait_tick(input string tag, input int budget);
    for (int i = 0; i < budget && !bif.timer_tick; i++) step();
    check_val(tag, {31'd0, bif.timer_tick}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_state"}, {29'd0, bif.state}, 32'd0);
    check_val({tag, "_round"}, {29'd0, bif.round_num}, 32'd0);
    check_val({tag, "_run"},   {31'd0, bif.timer_run}, 32'd0);
    check_val({tag, "_tick"},  {31'd0, bif.timer_tick}, 32'd0);
    check_val({tag, "_rend"},  {31'd0, bif.round_end}, 32'd0);
    check_val({tag, "_gover"}, {31'd0, bif.game_over}, 32'd0);
  endtask

  int ticks;
  int first_tick;
  int re1;
  int re2;

  initial begin
    reset = 1'b1;
    bif.start = 1'b0;
    bif.pause = 1'b0;
    bif.stop  = 1'b0;
    model_en   = 1'b0;
    done_force = 1'b0;
    step();
    step();
    check_reset_outputs("rst");
    reset = 1'b0;
    step();
    check_val("idle_after_rst", {29'd0, bif.state}, 32'd0);

    // Start, then timer_done during READY is ignored.
    bif.start = 1'b1; step(); bif.start = 1'b0;
    check_val("start_ready", {29'd0, bif.state}, 32'd1);
    check_val("start_round", {29'd0, bif.round_num}, 32'd1);
    done_force = 1'b1; step(); done_force = 1'b0;
    check_val("done_in_ready", {29'd0, bif.state}, 32'd1);
    step();
    check_val("ready_last", {29'd0, bif.state}, 32'd1);
    step();
    check_val("run_entry", {29'd0, bif.state}, 32'd2);
    check_val("run_timer_run", {31'd0, bif.timer_run}, 32'd1);
    bif.start = 1'b1; step(); bif.start = 1'b0;
    check_val("start_in_run", {29'd0, bif.state}, 32'd2);

    // stop beats timer_done.
    bif.stop = 1'b1; done_force = 1'b1; step(); bif.stop = 1'b0; done_force = 1'b0;
    check_val("stop_done_state", {29'd0, bif.state}, 32'd0);
    check_val("stop_done_rend", {31'd0, bif.round_end}, 32'd0);
    check_val("stop_done_round", {29'd0, bif.round_num}, 32'd0);

    // timer_done beats pause.
    bif.start = 1'b1; step(); bif.start = 1'b0;
    wait_state("wait_run_a", 3'd2, 10);
    done_force = 1'b1; bif.pause = 1'b1; step(); done_force = 1'b0; bif.pause = 1'b0;
    check_val("done_pause_state", {29'd0, bif.state}, 32'd4);
    check_val("done_pause_rend", {31'd0, bif.round_end}, 32'd1);
    check_val("rend_timer_run", {31'd0, bif.timer_run}, 32'd0);
    step();
    check_val("next_round_state", {29'd0, bif.state}, 32'd1);
    check_val("next_round_num", {29'd0, bif.round_num}, 32'd2);

    wait_state("wait_run_b", 3'd2, 10);
    wait_tick("first_tick_b", 10);
    step();
    step();
    bif.pause = 1'b1; step(); bif.pause = 1'b0;
`ifdef ROUND_SEQ_PAUSE_EN
    check_val("paused_state", {29'd0, bif.state}, 32'd3);
    check_val("paused_run", {31'd0, bif.timer_run}, 32'd1);
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bif.timer_tick) ticks++;
    end
    check_val("paused_ticks", ticks, 32'd0);
    check_val("paused_hold", {29'd0, bif.state}, 32'd3);
    bif.pause = 1'b1; step(); bif.pause = 1'b0;
    check_val("resume_state", {29'd0, bif.state}, 32'd2);
    check_val("resume_tick_p1", {31'd0, bif.timer_tick}, 32'd0);
    step();
    check_val("resume_tick_p2", {31'd0, bif.timer_tick}, 32'd1);
`else
    check_val("nopause_state", {29'd0, bif.state}, 32'd2);
    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      if (bif.timer_tick) ticks++;
      step();
    end
    check_val("nopause_ticks", ticks, 32'd2);
    check_val("nopause_hold", {29'd0, bif.state}, 32'd2);
`endif
    bif.stop = 1'b1; step(); bif.stop = 1'b0;
    check_val("stop_run", {29'd0, bif.state}, 32'd0);

    // Full two-round game against the timer model.
    model_en = 1'b1;
    step();
    bif.start = 1'b1; step(); bif.start = 1'b0;
    ticks = 0; first_tick = 0; re1 = 0; re2 = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) step();
      if (bif.timer_tick) begin
        ticks++;
        if (first_tick == 0) first_tick = n;
      end
      if (bif.round_end) begin
        if (re1 == 0) re1 = n;
        else if (re2 == 0) re2 = n;
      end
    end
    check_val("game_ticks", ticks, 32'd6);
    check_val("game_first_tick", first_tick, 32'd7);
    check_val("game_round_end1", re1, 32'd17);
    check_val("game_round_end2", re2, 32'd34);
    check_val("game_over_state", {29'd0, bif.state}, 32'd5);
    check_val("game_over_flag", {31'd0, bif.game_over}, 32'd1);
    check_val("game_over_round", {29'd0, bif.round_num}, 32'd2);

    // Restart from GAME_OVER.
    bif.start = 1'b1; step(); bif.start = 1'b0;
    check_val("restart_state", {29'd0, bif.state}, 32'd1);
    check_val("restart_round", {29'd0, bif.round_num}, 32'd1);
    check_val("restart_gover", {31'd0, bif.game_over}, 32'd0);

    // Asynchronous reset mid-RUN.
    wait_state("wait_run_c", 3'd2, 10);
    step();
    step();
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_rst");
    step();
    reset = 1'b0;
    step();
    check_val("post_rst_state", {29'd0, bif.state}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
